// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state encoding for the sequential-circuits counters
//
// Purpose: state enum and encoding width used by counter_down_sync and the
// other library counters. No ports.
package counter_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/counter_prescaler.sv
// rtl/counter_prescaler.sv - programmable tick divider for the down counter
//
// Purpose: emits a one-cycle tick every div_i+1 enabled cycles.
// Ports:
//   clk_i     in  1           clock, rising edge
//   resetn_i  in  1           synchronous active-low reset
//   clear_i   in  1           restart the divide phase (wins over en_i)
//   en_i      in  1           count enabled cycles
//   div_i     in  PRESCALE_W  divide value; 0 = tick every enabled cycle
//   tick_o    out 1           tick pulse
module counter_prescaler #(
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  clear_i,
  input  logic                  en_i,
  input  logic [PRESCALE_W-1:0] div_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] pre_q;
  logic [PRESCALE_W-1:0] pre_d;
  logic                  wrap;

  assign wrap   = (pre_q == div_i);
  assign tick_o = en_i && !clear_i && wrap;

  always_comb begin
    pre_d = pre_q;
    if (clear_i) begin
      pre_d = '0;
    end else if (en_i) begin
      pre_d = wrap ? '0 : pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/counter_down_sync.sv
// rtl/counter_down_sync.sv - loadable synchronous down counter / timer
//
// Purpose: load a value, count down once per tick after start, then stop
// (one-shot) or reload (auto-reload). Optional prescaler under macro
// COUNTER_DOWN_PRESCALE_EN.
// Ports:
//   clk           in  1           sole clock, rising edge
//   reset         in  1           synchronous active-low reset
//   load          in  1           load load_value into count and reload register
//   load_value    in  WIDTH       value to load
//   start         in  1           begin or resume counting
//   stop          in  1           pause counting, hold count
//   auto_reload   in  1           1 = periodic, 0 = one-shot
//   prescale_div  in  PRESCALE_W  tick every prescale_div+1 cycles (macro only)
//   count         out WIDTH       current count
//   busy          out 1           high in RUN
//   tc            out 1           one-cycle terminal-count pulse
//   done          out 1           one-shot completion level
module counter_down_sync
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  auto_reload,
`ifdef COUNTER_DOWN_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale_div,
`endif
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  tc,
  output logic                  done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             busy_q, busy_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic             term_evt;
  logic             tick;

`ifdef COUNTER_DOWN_PRESCALE_EN
  logic pre_clear;

  // Restart the divide phase whenever counting begins, resumes or is aborted,
  // so the first tick always lands prescale_div+1 cycles into RUN.
  assign pre_clear = load || stop || (start && (state_q != ST_RUN));

  counter_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk_i    (clk),
    .resetn_i (reset),
    .clear_i  (pre_clear),
    .en_i     (state_q == ST_RUN),
    .div_i    (prescale_div),
    .tick_o   (tick)
  );
`else
  // No prescaler: every RUN cycle is a tick; PRESCALE_W has no effect here.
  assign tick = (PRESCALE_W > 0) || 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      tc_q     <= tc_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    term_evt = 1'b0;
    if (load) begin
      state_d  = ST_IDLE;
      count_d  = load_value;
      reload_d = load_value;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (stop) begin
            state_d = ST_IDLE;
          end else if (tick) begin
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - 1'b1;
            end else begin
              term_evt = 1'b1;
              if (auto_reload) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = ST_DONE;
              end
            end
          end
        end
        ST_IDLE, ST_DONE: begin
          // A zero count completes immediately rather than underflowing.
          if (!stop && start) begin
            if (count_q != '0) begin
              state_d = ST_RUN;
            end else begin
              state_d  = ST_DONE;
              term_evt = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
    tc_d   = term_evt;
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign tc    = tc_q;
  assign done  = done_q;

endmodule

// File: doc/counter_down_sync.md
# counter_down_sync

Synchronous, loadable down counter/timer, the counting-down counterpart of the team's ripple up counters. A single clock drives every flop, with no derived clocks. A value is loaded, and on `start` the counter decrements once per tick to a terminal count. It then stops (one-shot) or reloads (auto-reload). It sits beside the up counters in the sequential-circuits library as the timeout/interval generator for control FSMs.

## Interface
Parameters:
- `WIDTH`, 4: counter and load-value width.
- `PRESCALE_W`, 4: prescaler divide-value width; used only with `COUNTER_DOWN_PRESCALE_EN`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on rising `clk`.
- `load`  in  1  load `load_value` into count and reload register.
- `load_value`  in  WIDTH  value to load.
- `start`  in  1  begin or resume counting.
- `stop`  in  1  pause counting, holding count.
- `auto_reload`  in  1  1 = periodic, 0 = one-shot; sampled at each terminal tick.
- `prescale_div`  in  PRESCALE_W  tick every `prescale_div`+1 cycles; present only with the macro.
- `count`  out  WIDTH  current count.
- `busy`  out  1  high in RUN.
- `tc`  out  1  one-cycle terminal-count pulse.
- `done`  out  1  one-shot completion level.

## Operation
- Reset (`reset`=0 at an edge): state IDLE; `count`=0, reload register=0, `busy`=0, `tc`=0, `done`=0; prescaler cleared.
- Priority within a cycle: reset > `load` > `stop` > `start`.
- States: IDLE, RUN, DONE. Outputs are registered and derived from state.
- Transitions:
  - `load` in any state: `count`/reload register ← `load_value`; `done`←0; next state IDLE. This aborts a run in progress.
  - IDLE or DONE, `start`, `count`≠0: RUN; `done`←0.
  - IDLE or DONE, `start`, `count`=0: DONE; `tc`=1 for one cycle; `done`=1; no decrement.
  - RUN, `stop`: IDLE; `count` held. A later `start` resumes from the held value.
  - RUN, `start`: ignored.
- Tick in RUN, `count`>1: `count`←`count`−1.
- Tick in RUN, `count`=1, `auto_reload`=0: `count`←0; `tc` pulse; state DONE; `done`=1.
- Tick in RUN, `count`=1, `auto_reload`=1: `count`←reload register; `tc` pulse; stay RUN. In auto-reload mode `count` never shows 0.
- Auto-reload with reload register=1: `tc` is asserted on every tick.
- `tc` never exceeds one cycle per tick.
- Arithmetic: unsigned WIDTH-bit; no underflow below 0 is possible.

## Timing
- `start` sampled at edge N: `busy`=1 after N.
- First tick at edge N+1; with a load of L, `tc`/`done` rise after edge N+L (L clocks, no prescaler). `busy` falls at the same edge.
- Auto-reload period is R ticks for reload value R.
- `load` or `stop` takes effect at the sampling edge. No further tick occurs after that edge.
- Reset mid-run: all outputs return to reset values after the sampling edge.

## Configuration
- `COUNTER_DOWN_PRESCALE_EN` defined:
  - `prescale_div` port exists.
  - A tick occurs every `prescale_div`+1 RUN cycles; 0 means every cycle.
  - Prescaler is cleared on `load`, `start` and `stop`, so the first tick lands `prescale_div`+1 cycles after entering RUN.
- Not defined: port and prescaler logic are absent; every RUN cycle is a tick.

## Structure
- Package `counter_pkg`: state enum (IDLE, RUN, DONE) and state-encoding width constant, shared with the other library counters.
- Sub-module `counter_prescaler`: clear input and tick-pulse output. It is instantiated only under the macro.

## Test plan
- Reset, then load 5, start at edge N → `count` 4,3,2,1,0 after N+1..N+5; `tc` and `done` high after N+5 only; `busy` 0 afterwards.
- Load 3, `auto_reload`=1, start → `count` 2,1,3,2,1,3…; `tc` pulse every 3 cycles; `done` stays 0.
- Load 9, start, stop after 4 ticks → `count`=5 held, `busy`=0; start again → continues 4,3,…
- Load 0, start → DONE next edge; one `tc` pulse; `count` stays 0.
- Load and stop asserted together mid-run with `load_value`=7 → `count`=7, IDLE. Reset mid-run → all outputs 0.
- Macro defined, `prescale_div`=2, load 2, start → decrements every 3 cycles; `tc` 6 cycles after start.
